// File: rtl/icache_direct.sv
// Direct-mapped, one-word-block I-cache: zero-cycle hits; a miss holds ihit=0 while an iREN/iwait fill runs, then replays.
// Defining ICACHE_STATS_EN adds saturating hit_count/miss_count output ports.
module icache_direct #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t           r_state, w_state_nxt;
   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [SETS];
   logic [31:0]      r_data [SETS];
   logic [31:0]      r_miss_addr, w_miss_addr_nxt;
   logic [31:0]      w_word_addr;
   logic [IDX_W-1:0] w_idx, w_fill_idx;
   logic [TAG_W-1:0] w_tag, w_fill_tag;
   logic             w_lookup_hit, w_fill_done, w_miss;

   assign w_word_addr  = imemaddr & 32'hFFFF_FFFC;
   assign w_idx        = w_word_addr[IDX_W+1:2];
   assign w_tag        = w_word_addr[31:IDX_W+2];
   assign w_fill_idx   = r_miss_addr[IDX_W+1:2];
   assign w_fill_tag   = r_miss_addr[31:IDX_W+2];
   assign w_lookup_hit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_fill_done  = (r_state == FILL) & ~iwait;
   assign w_miss       = (r_state == IDLE) & imemREN & ~w_lookup_hit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_miss_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_miss_addr <= w_miss_addr_nxt;
      end
   end

   // Valid bits carry the reset; tag/data are meaningless until valid is set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid <= '0;
      end else if (w_fill_done) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_fill_done) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= iload;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_miss_addr_nxt = r_miss_addr;
      ihit            = 1'b0;
      imemload        = '0;
      iREN            = 1'b0;
      iaddr           = '0;
      case (r_state)
         IDLE: begin
            if (w_lookup_hit) begin
               ihit     = 1'b1;
               imemload = r_data[w_idx];
            end else if (imemREN) begin
               w_miss_addr_nxt = w_word_addr;
               w_state_nxt     = FILL;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = r_miss_addr;
            if (!iwait) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && hit_count != 32'hFFFF_FFFF) begin
            hit_count <= hit_count + 32'd1;
         end
         if (w_miss && miss_count != 32'hFFFF_FFFF) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: expected fetch words queue up at request time and are popped on ihit.
module tb_icache_direct;
   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          n_cmp = 0;
   int          n_fail = 0;
   int          exp_hits = 0;
   int          exp_misses = 0;
   logic [31:0] sb_q[$];

   localparam logic [31:0] D0   = 32'h1111_0000;
   localparam logic [31:0] D40  = 32'h8C22_0004;
   localparam logic [31:0] D440 = 32'h2042_0001;
   localparam logic [31:0] D80  = 32'hAC01_0080;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   icache_direct #(.SETS(16)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_hit(input string tag);
      logic [31:0] e;
      check({tag, ".ihit"}, {31'b0, ihit}, 32'd1);
      check({tag, ".iren"}, {31'b0, iREN}, 32'd0);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, ".data"}, imemload, e);
      end
      exp_hits++;
   endtask

   task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data, input string tag);
      step();
      imemREN  = 1'b1;
      imemaddr = addr;
      sb_q.push_back(data);
      @(negedge CLK);
      check_hit(tag);
   endtask

   task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data,
                             input int n_wait, input string tag);
      step();
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = 1'b1;
      iload    = JUNK;
      sb_q.push_back(data);
      @(negedge CLK);
      check({tag, ".idle_ihit"}, {31'b0, ihit}, 32'd0);
      check({tag, ".idle_iren"}, {31'b0, iREN}, 32'd0);
      exp_misses++;
      for (int i = 0; i < n_wait; i++) begin
         step();
         @(negedge CLK);
         check({tag, ".fill_iren"}, {31'b0, iREN}, 32'd1);
         check({tag, ".fill_iaddr"}, iaddr, {addr[31:2], 2'b00});
         check({tag, ".fill_load"}, imemload, 32'd0);
      end
      step();
      iwait = 1'b0;
      iload = data;
      @(negedge CLK);
      check({tag, ".done_iren"}, {31'b0, iREN}, 32'd1);
      check({tag, ".done_ihit"}, {31'b0, ihit}, 32'd0);
      step();
      iwait = 1'b1;
      iload = JUNK;
      @(negedge CLK);
      check_hit({tag, ".replay"});
   endtask

   initial begin
      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = '0;
      iwait    = 1'b1;
      iload    = '0;

      // Reset values
      @(negedge CLK);
      check("rst.ihit", {31'b0, ihit}, 32'd0);
      check("rst.iren", {31'b0, iREN}, 32'd0);
      check("rst.load", imemload, 32'd0);
      check("rst.iaddr", iaddr, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      fetch_miss(32'h0, D0, 1, "t1");

      // Cold miss with three busy cycles, then a zero-cycle re-read
      fetch_miss(32'h40, D40, 3, "t2");
      fetch_hit(32'h42, D40, "t2.reread");

      // Same index, different tag evicts the previous line
      fetch_miss(32'h440, D440, 2, "t3.conflict");
      fetch_miss(32'h40, D40, 1, "t3.refetch");

      // Request dropped mid-fill: the fill still lands at the latched address
      step();
      imemREN  = 1'b1;
      imemaddr = 32'h80;
      @(negedge CLK);
      check("t4.idle_iren", {31'b0, iREN}, 32'd0);
      exp_misses++;
      step();
      imemREN  = 1'b0;
      imemaddr = 32'h3C0;
      @(negedge CLK);
      check("t4.fill_iren", {31'b0, iREN}, 32'd1);
      check("t4.fill_iaddr", iaddr, 32'h80);
      step();
      iwait = 1'b0;
      iload = D80;
      @(negedge CLK);
      check("t4.done_iren", {31'b0, iREN}, 32'd1);
      step();
      iwait = 1'b1;
      iload = JUNK;
      @(negedge CLK);
      check("t4.idle_noreq_ihit", {31'b0, ihit}, 32'd0);
      check("t4.idle_noreq_iren", {31'b0, iREN}, 32'd0);
      fetch_hit(32'h80, D80, "t4.later");

      // Reset asserted during a fill drops iREN immediately and flushes the cache
      step();
      imemREN  = 1'b1;
      imemaddr = 32'h107;
      @(negedge CLK);
      check("t5.idle_iren", {31'b0, iREN}, 32'd0);
      step();
      @(negedge CLK);
      check("t5.fill_iren", {31'b0, iREN}, 32'd1);
      check("t5.fill_iaddr", iaddr, 32'h104);
      #1;
      RST     = 1'b1;
      imemREN = 1'b0;
      #1;
      check("t5.rst_iren", {31'b0, iREN}, 32'd0);
      check("t5.rst_iaddr", iaddr, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      sb_q.delete();
      exp_hits   = 0;
      exp_misses = 0;
`ifdef ICACHE_STATS_EN
      check("t6.rst_hits", hit_count, 32'd0);
      check("t6.rst_misses", miss_count, 32'd0);
`endif
      fetch_miss(32'h40, D40, 3, "t5.flushed");

      // Repeat of the cold-miss and conflict sequence for the statistics
      fetch_hit(32'h40, D40, "t6.hit");
      fetch_miss(32'h440, D440, 1, "t6.conflict");
      fetch_miss(32'h40, D40, 1, "t6.refetch");
      step();
      imemREN = 1'b0;
      @(negedge CLK);
      check("t6.sb_empty", sb_q.size(), 32'd0);
`ifdef ICACHE_STATS_EN
      check("t6.miss_count", miss_count, 32'd3);
      check("t6.miss_sb", miss_count, exp_misses);
      check("t6.hit_count", hit_count, exp_hits);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
